regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_if.sv | 37 +++
 rtl/regfile_reg_bank.sv | 66 ++++++
 rtl/regfile.sv | 134 +++++++++++++
 tb/tb_regfile.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the GPR/FPR register file: sizes, fpoint bank
// encodings, pair-FSM state type and a register-pair helper.
package regfile_pkg;

   localparam int NREGS  = 32;
   localparam int XLEN   = 32;
   localparam int REG_AW = $clog2(NREGS);

   // Bank/format select carried on fpoint
   typedef enum logic [1:0] {
      FP_GPR    = 2'b00,
      FP_SINGLE = 2'b01,
      FP_DLO    = 2'b10,
      FP_DHI    = 2'b11
   } fpoint_e;

   // Double-pair assembly state
   typedef logic [0:0] pair_state_t;
   localparam pair_state_t ST_IDLE = 1'b0;
   localparam pair_state_t ST_HALF = 1'b1;

   // Even register of the aligned pair containing r
   function automatic logic [REG_AW-1:0] pair_even(input logic [REG_AW-1:0] r);
      return {r[REG_AW-1:1], 1'b0};
   endfunction

endpackage

// File: rtl/regfile_if.sv
// Write-back and read-port bundle of the register file. The master side
// drives addresses/write data; the slave side (the register file) returns
// read data and pair status.
interface regfile_if
   import regfile_pkg::*;
   ();

   logic              regwr;
   logic [REG_AW-1:0] rw;
   logic [XLEN-1:0]   busW;
   logic [1:0]        fpoint;

   logic [REG_AW-1:0] ra;
   logic [REG_AW-1:0] rb;
   logic [XLEN-1:0]   busA;
   logic [XLEN-1:0]   busB;

   logic [REG_AW-1:0] fa;
   logic [REG_AW-1:0] fb;
   logic [XLEN-1:0]   fbusA;
   logic [XLEN-1:0]   fbusB;
   logic [2*XLEN-1:0] fdbusA;

   logic              pair_pending;
   logic              pair_err;

   modport master (
      output regwr, rw, busW, fpoint, ra, rb, fa, fb,
      input  busA, busB, fbusA, fbusB, fdbusA, pair_pending, pair_err
   );

   modport slave (
      input  regwr, rw, busW, fpoint, ra, rb, fa, fb,
      output busA, busB, fbusA, fbusB, fdbusA, pair_pending, pair_err
   );

endinterface

// File: rtl/regfile_reg_bank.sv
// Register bank with one write port (single or aligned-pair write), three
// combinational read ports and write-through bypass. Reads look at the
// next-state array, so a register being written this cycle returns the data
// that lands at the coming edge. ZERO_R0 makes entry 0 read as zero and
// ignore writes.
module reg_bank
   import regfile_pkg::*;
#(
   parameter int DATA_W  = XLEN,
   parameter bit ZERO_R0 = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              wpair,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] wdata_hi,
   input  logic [REG_AW-1:0] raddr_a,
   input  logic [REG_AW-1:0] raddr_b,
   input  logic [REG_AW-1:0] raddr_c,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   output logic [DATA_W-1:0] rdata_c
);

   localparam int DEPTH = 2 ** REG_AW;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [REG_AW-1:0] lo_addr;
   logic [REG_AW-1:0] hi_addr;

   // A pair write lands wdata in the even slot and wdata_hi in the odd slot
   assign lo_addr = wpair ? pair_even(waddr) : waddr;
   assign hi_addr = pair_even(waddr) | REG_AW'(1);

   // Next-state array: current contents with this cycle's write applied
   always_comb begin
      mem_d = mem_q;
      if (we) begin
         if (!(ZERO_R0 && lo_addr == '0)) begin
            mem_d[lo_addr] = wdata;
         end
         if (wpair) begin
            mem_d[hi_addr] = wdata_hi;
         end
      end
   end

   // Storage update; reset clears every entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata_a = (ZERO_R0 && raddr_a == '0) ? '0 : mem_d[raddr_a];
   assign rdata_b = (ZERO_R0 && raddr_b == '0) ? '0 : mem_d[raddr_b];
   assign rdata_c = (ZERO_R0 && raddr_c == '0) ? '0 : mem_d[raddr_c];

endmodule

// File: rtl/regfile.sv
// Integer/floating-point register file. Holds a GPR bank (r0 hard-wired to
// zero) and an FPR bank, plus the pair FSM that assembles a double-precision
// write from a low half and a high half and commits both halves to an
// aligned FPR pair in a single edge.
module regfile
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   regfile_if.slave   bus
);

   pair_state_t       state_q, state_d;
   logic [XLEN-1:0]   lo_data_q, lo_data_d;
   logic [REG_AW-1:0] pair_base_q, pair_base_d;
   logic              pair_err_q, pair_err_d;

   logic              gpr_we;
   logic              fpr_we;
   logic              fpr_pair;
   logic [REG_AW-1:0] fpr_waddr;
   logic [XLEN-1:0]   fpr_wdata;
   logic [XLEN-1:0]   fpr_wdata_hi;

   logic [XLEN-1:0]   fpr_rd_a;
   logic [XLEN-1:0]   fpr_rd_c;
   logic [XLEN-1:0]   gpr_rd_unused;

   // Write decode and pair FSM next state
   always_comb begin
      state_d      = state_q;
      lo_data_d    = lo_data_q;
      pair_base_d  = pair_base_q;
      pair_err_d   = 1'b0;
      gpr_we       = 1'b0;
      fpr_we       = 1'b0;
      fpr_pair     = 1'b0;
      fpr_waddr    = bus.rw;
      fpr_wdata    = bus.busW;
      fpr_wdata_hi = bus.busW;
      if (bus.regwr) begin
         case (fpoint_e'(bus.fpoint))
            FP_GPR: begin
               gpr_we = 1'b1;
            end
            FP_SINGLE: begin
               fpr_we = 1'b1;
            end
            FP_DLO: begin
               // A second low half while one is held replaces it and flags the sequence
               lo_data_d   = bus.busW;
               pair_base_d = pair_even(bus.rw);
               state_d     = ST_HALF;
               pair_err_d  = (state_q == ST_HALF);
            end
            FP_DHI: begin
               // Any high half ends the pair; only a matching one commits
               state_d = ST_IDLE;
               if (state_q == ST_HALF &&
                   bus.rw[REG_AW-1:1] == pair_base_q[REG_AW-1:1]) begin
                  fpr_we    = 1'b1;
                  fpr_pair  = 1'b1;
                  fpr_waddr = pair_base_q;
                  fpr_wdata = lo_data_q;
               end else begin
                  pair_err_d = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Pair FSM registers; reset drops any pending half
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         lo_data_q   <= '0;
         pair_base_q <= '0;
         pair_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         lo_data_q   <= lo_data_d;
         pair_base_q <= pair_base_d;
         pair_err_q  <= pair_err_d;
      end
   end

   reg_bank #(
      .DATA_W  (XLEN),
      .ZERO_R0 (1'b1)
   ) u_gpr (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (gpr_we),
      .wpair    (1'b0),
      .waddr    (bus.rw),
      .wdata    (bus.busW),
      .wdata_hi (bus.busW),
      .raddr_a  (bus.ra),
      .raddr_b  (bus.rb),
      .raddr_c  ('0),
      .rdata_a  (bus.busA),
      .rdata_b  (bus.busB),
      .rdata_c  (gpr_rd_unused)
   );

   // Third FPR port reads the partner of fa so the pair view needs no extra port
   reg_bank #(
      .DATA_W  (XLEN),
      .ZERO_R0 (1'b0)
   ) u_fpr (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (fpr_we),
      .wpair    (fpr_pair),
      .waddr    (fpr_waddr),
      .wdata    (fpr_wdata),
      .wdata_hi (fpr_wdata_hi),
      .raddr_a  (bus.fa),
      .raddr_b  (bus.fb),
      .raddr_c  (bus.fa ^ REG_AW'(1)),
      .rdata_a  (fpr_rd_a),
      .rdata_b  (bus.fbusB),
      .rdata_c  (fpr_rd_c)
   );

   assign bus.fbusA        = fpr_rd_a;
   assign bus.fdbusA       = bus.fa[0] ? {fpr_rd_a, fpr_rd_c} : {fpr_rd_c, fpr_rd_a};
   assign bus.pair_pending = (state_q == ST_HALF);
   assign bus.pair_err     = pair_err_q;

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed write/read sequences with literal expectations,
// plus a register-level model checked against every output on each falling
// clock edge while out of reset.
module tb_regfile;
   import regfile_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errs   = 0;

   regfile_if rf_if ();

   regfile dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (rf_if)
   );

   always #5 clk = ~clk;

   // Model state: architectural register contents and pair bookkeeping
   logic [31:0] m_gpr [32];
   logic [31:0] m_fpr [32];
   logic [31:0] m_lo;
   logic [4:0]  m_base;
   logic        m_pend;
   logic        m_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model update from the rules for each write kind
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            m_gpr[i] <= '0;
            m_fpr[i] <= '0;
         end
         m_lo   <= '0;
         m_base <= '0;
         m_pend <= 1'b0;
         m_err  <= 1'b0;
      end else begin
         m_err <= 1'b0;
         if (rf_if.regwr) begin
            case (rf_if.fpoint)
               2'b00: if (rf_if.rw != 0) m_gpr[rf_if.rw] <= rf_if.busW;
               2'b01: m_fpr[rf_if.rw] <= rf_if.busW;
               2'b10: begin
                  if (m_pend) m_err <= 1'b1;
                  m_pend <= 1'b1;
                  m_lo   <= rf_if.busW;
                  m_base <= rf_if.rw - (rf_if.rw % 2);
               end
               default: begin
                  if (m_pend && (rf_if.rw / 2) == (m_base / 2)) begin
                     m_fpr[m_base]     <= m_lo;
                     m_fpr[m_base + 1] <= rf_if.busW;
                  end else begin
                     m_err <= 1'b1;
                  end
                  m_pend <= 1'b0;
               end
            endcase
         end
      end
   end

   function automatic logic [31:0] exp_gpr(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (rf_if.regwr && rf_if.fpoint == 2'b00 && rf_if.rw == a) return rf_if.busW;
      return m_gpr[a];
   endfunction

   function automatic logic [31:0] exp_fpr(input logic [4:0] a);
      if (rf_if.regwr && rf_if.fpoint == 2'b01 && rf_if.rw == a) return rf_if.busW;
      if (rf_if.regwr && rf_if.fpoint == 2'b11 && m_pend && (rf_if.rw / 2) == (m_base / 2)) begin
         if (a == m_base) return m_lo;
         if (32'(a) == 32'(m_base) + 1) return rf_if.busW;
      end
      return m_fpr[a];
   endfunction

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_busA",   64'(rf_if.busA),  64'(exp_gpr(rf_if.ra)));
         chk("m_busB",   64'(rf_if.busB),  64'(exp_gpr(rf_if.rb)));
         chk("m_fbusA",  64'(rf_if.fbusA), 64'(exp_fpr(rf_if.fa)));
         chk("m_fbusB",  64'(rf_if.fbusB), 64'(exp_fpr(rf_if.fb)));
         chk("m_fdbusA", rf_if.fdbusA,
             {exp_fpr(rf_if.fa | 5'd1), exp_fpr(rf_if.fa & 5'h1e)});
         chk("m_pending", 64'(rf_if.pair_pending), 64'(m_pend));
         chk("m_err",     64'(rf_if.pair_err),     64'(m_err));
      end
   end

   task automatic wr(input logic [1:0] fp, input logic [4:0] r, input logic [31:0] d);
      rf_if.regwr  = 1'b1;
      rf_if.fpoint = fp;
      rf_if.rw     = r;
      rf_if.busW   = d;
   endtask

   task automatic idle();
      rf_if.regwr = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rf_if.regwr  = 1'b0;
      rf_if.rw     = '0;
      rf_if.busW   = '0;
      rf_if.fpoint = 2'b00;
      rf_if.ra     = '0;
      rf_if.rb     = '0;
      rf_if.fa     = '0;
      rf_if.fb     = '0;
      rst_n        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busA",    64'(rf_if.busA),         64'h0);
      chk("rst_fbusA",   64'(rf_if.fbusA),        64'h0);
      chk("rst_fdbusA",  rf_if.fdbusA,            64'h0);
      chk("rst_pending", 64'(rf_if.pair_pending), 64'h0);
      chk("rst_err",     64'(rf_if.pair_err),     64'h0);
      rst_n = 1'b1;

      // GPR write with same-cycle bypass, then registered read
      rf_if.ra = 5'd5;
      wr(2'b00, 5'd5, 32'h1234_5678);
      #1 chk("gpr5_bypass", 64'(rf_if.busA), 64'h1234_5678);
      tick(); idle();
      #1 chk("gpr5_read", 64'(rf_if.busA), 64'h1234_5678);

      // r0 never changes
      rf_if.ra = 5'd0;
      wr(2'b00, 5'd0, 32'hFFFF_FFFF);
      #1 chk("r0_bypass", 64'(rf_if.busA), 64'h0);
      tick(); idle();
      #1 chk("r0_read", 64'(rf_if.busA), 64'h0);

      // Double pair f4/f5
      rf_if.fa = 5'd4;
      rf_if.fb = 5'd5;
      wr(2'b10, 5'd4, 32'hAAAA_0000);
      #1 chk("lo_hidden", rf_if.fdbusA, 64'h0);
      tick();
      #1 chk("pair_pend_on", 64'(rf_if.pair_pending), 64'h1);
      chk("f4_unchanged", 64'(rf_if.fbusA), 64'h0);
      wr(2'b11, 5'd5, 32'hBBBB_1111);
      #1 chk("pair_bypass", rf_if.fdbusA, 64'hBBBB_1111_AAAA_0000);
      tick(); idle();
      #1 chk("pair_pend_off", 64'(rf_if.pair_pending), 64'h0);
      chk("pair_commit", rf_if.fdbusA, 64'hBBBB_1111_AAAA_0000);
      chk("pair_no_err", 64'(rf_if.pair_err), 64'h0);

      // High half while idle
      rf_if.fa = 5'd8;
      wr(2'b01, 5'd8, 32'h1111_2222);
      tick();
      wr(2'b11, 5'd8, 32'hDEAD_BEEF);
      tick(); idle();
      #1 chk("idle_hi_err", 64'(rf_if.pair_err), 64'h1);
      chk("idle_hi_f8", 64'(rf_if.fbusA), 64'h1111_2222);
      tick();
      #1 chk("idle_hi_err_pulse", 64'(rf_if.pair_err), 64'h0);

      // Mismatched pair
      rf_if.fa = 5'd6;
      rf_if.fb = 5'd7;
      wr(2'b10, 5'd6, 32'h6666_6666);
      tick();
      wr(2'b11, 5'd9, 32'h9999_9999);
      tick(); idle();
      #1 chk("mis_err", 64'(rf_if.pair_err), 64'h1);
      chk("mis_pend", 64'(rf_if.pair_pending), 64'h0);
      chk("mis_f6", 64'(rf_if.fbusA), 64'h0);
      chk("mis_f7", 64'(rf_if.fbusB), 64'h0);

      // Low half replaced while pending
      rf_if.fa = 5'd10;
      rf_if.fb = 5'd12;
      wr(2'b10, 5'd10, 32'hA0A0_A0A0);
      tick();
      wr(2'b10, 5'd12, 32'hC0C0_C0C0);
      tick();
      #1 chk("dbl_lo_err", 64'(rf_if.pair_err), 64'h1);
      chk("dbl_lo_pend", 64'(rf_if.pair_pending), 64'h1);
      wr(2'b11, 5'd13, 32'hD0D0_D0D0);
      tick(); idle();
      #1 chk("dbl_lo_f10", 64'(rf_if.fbusA), 64'h0);
      chk("dbl_lo_f12", 64'(rf_if.fbusB), 64'hC0C0_C0C0);
      rf_if.fa = 5'd13;
      #1 chk("dbl_lo_pair", rf_if.fdbusA, 64'hD0D0_D0D0_C0C0_C0C0);

      // Single writes proceed while a half is held
      rf_if.ra = 5'd3;
      rf_if.fa = 5'd20;
      rf_if.fb = 5'd15;
      wr(2'b10, 5'd14, 32'hE0E0_E0E0);
      tick();
      wr(2'b00, 5'd3, 32'h3333_3333);
      tick();
      #1 chk("half_gpr_pend", 64'(rf_if.pair_pending), 64'h1);
      chk("half_gpr_r3", 64'(rf_if.busA), 64'h3333_3333);
      wr(2'b01, 5'd20, 32'h2020_2020);
      tick();
      wr(2'b11, 5'd14, 32'hF0F0_F0F0);
      tick(); idle();
      #1 chk("half_fpr_f20", 64'(rf_if.fbusA), 64'h2020_2020);
      chk("half_f15", 64'(rf_if.fbusB), 64'hF0F0_F0F0);
      chk("half_pend_off", 64'(rf_if.pair_pending), 64'h0);
      rf_if.fa = 5'd14;
      #1 chk("half_f14", 64'(rf_if.fbusA), 64'hE0E0_E0E0);

      // regwr low changes nothing
      rf_if.fpoint = 2'b11;
      rf_if.rw     = 5'd14;
      rf_if.busW   = 32'h0;
      tick();
      #1 chk("nowr_err", 64'(rf_if.pair_err), 64'h0);
      chk("nowr_f14", 64'(rf_if.fbusA), 64'hE0E0_E0E0);
      rf_if.fpoint = 2'b10;
      tick();
      #1 chk("nowr_pend", 64'(rf_if.pair_pending), 64'h0);

      // Reset while a half is held
      rf_if.fa = 5'd2;
      rf_if.ra = 5'd5;
      wr(2'b10, 5'd2, 32'h2222_2222);
      tick(); idle();
      #1 chk("rh_pend", 64'(rf_if.pair_pending), 64'h1);
      rst_n = 1'b0;
      #1 chk("rh_pend_async", 64'(rf_if.pair_pending), 64'h0);
      chk("rh_gpr5", 64'(rf_if.busA), 64'h0);
      tick();
      tick();
      rst_n = 1'b1;
      #1 chk("rh_f2", 64'(rf_if.fbusA), 64'h0);
      chk("rh_err", 64'(rf_if.pair_err), 64'h0);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
